// File: rtl/mcs4_bus_tracer.sv
// Passive MCS-4 bus tracer: follows the 8-phase instruction cycle from PHI2/SYNC and
// queues one {addr, OPR, OPA} record per fetched instruction in a FWFT FIFO.
module mcs4_bus_tracer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        PHI2_i,
  input  logic                        SYNC_i,
  input  logic [3:0]                  D_i,
  input  logic                        en_i,
  output logic [19:0]                 trace_data_o,
  output logic                        trace_valid_o,
  input  logic                        trace_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        locked_o,
  output logic [CNT_W-1:0]            sync_err_cnt_o,
  output logic [CNT_W-1:0]            ovf_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];

  typedef enum logic { HUNT, TRACK } state_t;

  state_t      state, state_nxt;
  logic [2:0]  phase, phase_nxt;
  logic [4:0]  got, got_nxt;     // one bit per captured phase A1..M2
  logic        phi2_q, tick, sync_err, push;
  logic [11:0] addr;
  logic [3:0]  opr, opa;

  logic [19:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          full, pop, wr_en, ovf;

  assign tick = phi2_q & ~PHI2_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; combinational blocks use blocking assignments.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phi2_q <= 1'b0;
      state  <= HUNT;
      phase  <= 3'd0;
      got    <= 5'd0;
    end else begin
      phi2_q <= PHI2_i;
      state  <= state_nxt;
      phase  <= phase_nxt;
      got    <= got_nxt;
    end
  end

  // NOTE: every variable gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    got_nxt   = got;
    sync_err  = 1'b0;
    push      = 1'b0;
    if (tick) begin
      if (state == HUNT) begin
        if (SYNC_i) begin
          state_nxt = TRACK;
          phase_nxt = 3'd0;
          got_nxt   = 5'd0;
        end
      end else if (SYNC_i) begin
        phase_nxt = 3'd0;
        got_nxt   = 5'd0;
        sync_err  = (phase != 3'd7);
      end else if (phase == 3'd7) begin
        state_nxt = HUNT;
        phase_nxt = 3'd0;
        got_nxt   = 5'd0;
        sync_err  = 1'b1;
      end else begin
        phase_nxt = phase + 3'd1;
        if (phase <= 3'd4) got_nxt[phase] = 1'b1;
        push = (phase == 3'd5) & en_i & (&got);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr <= 12'd0;
      opr  <= 4'd0;
      opa  <= 4'd0;
    end else if (tick && state == TRACK && !SYNC_i) begin
      case (phase)
        3'd0:    addr[3:0]  <= D_i;
        3'd1:    addr[7:4]  <= D_i;
        3'd2:    addr[11:8] <= D_i;
        3'd3:    opr        <= D_i;
        3'd4:    opa        <= D_i;
        default: ;
      endcase
    end
  end

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign full  = (level == FULL_LVL);
  assign pop   = trace_valid_o & trace_ready_i;
  assign wr_en = push & (~full | pop);
  assign ovf   = push & full & ~pop;

  // NOTE: the storage array is not reset; the level counter alone decides which
  // entries are meaningful, and the read data is masked while empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= {addr, opr, opa};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      sync_err_cnt_o <= '0;
      ovf_cnt_o      <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      if (sync_err && sync_err_cnt_o != '1) sync_err_cnt_o <= sync_err_cnt_o + 1'b1;
      if (ovf && ovf_cnt_o != '1)           ovf_cnt_o      <= ovf_cnt_o + 1'b1;
    end
  end

  assign trace_valid_o = (level != '0);
  assign trace_data_o  = trace_valid_o ? mem[rd_ptr] : 20'd0;
  assign fifo_level_o  = level;
  assign locked_o      = (state == TRACK);

endmodule

// File: tb/tb_mcs4_bus_tracer.sv
// Directed bench for mcs4_bus_tracer: stimulus queues expected records, an independent
// monitor pops them on each accepted handshake and checks stall stability.
module tb_mcs4_bus_tracer;

  logic        clk = 1'b0;
  logic        rst, phi2, sync, en, ready;
  logic [3:0]  d;
  logic [19:0] trace_data;
  logic        trace_valid, locked;
  logic [4:0]  fifo_level;
  logic [7:0]  sync_err_cnt, ovf_cnt;

  int checks = 0;
  int errors = 0;
  logic [19:0] sb[$];
  logic toggle_ready = 1'b0;

  mcs4_bus_tracer #(.FIFO_DEPTH(16), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .PHI2_i(phi2), .SYNC_i(sync), .D_i(d), .en_i(en),
    .trace_data_o(trace_data), .trace_valid_o(trace_valid), .trace_ready_i(ready),
    .fifo_level_o(fifo_level), .locked_o(locked),
    .sync_err_cnt_o(sync_err_cnt), .ovf_cnt_o(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus phase: PHI2 high for a clock, then low; the DUT ticks on the following edge.
  task automatic phase(input logic s, input logic [3:0] dv, input logic pop_tick = 1'b0);
    @(negedge clk); phi2 = 1'b1; sync = s; d = dv;
    @(negedge clk); phi2 = 1'b0; if (pop_tick) ready = 1'b1;
    @(posedge clk);
    if (pop_tick) begin #2; ready = 1'b0; end
  endtask

  task automatic instr(input logic [11:0] a, input logic [3:0] r, input logic [3:0] o,
                       input logic en_v, input logic exp_push,
                       input logic x3_sync = 1'b1, input logic pop_x1 = 1'b0);
    if (exp_push) sb.push_back({a, r, o});
    en = en_v;
    phase(1'b0, a[3:0]);
    phase(1'b0, a[7:4]);
    phase(1'b0, a[11:8]);
    phase(1'b0, r);
    phase(1'b0, o);
    phase(1'b0, 4'h0, pop_x1);
    phase(1'b0, 4'h0);
    phase(x3_sync, 4'h0);
    en = 1'b1;
  endtask

  task automatic drain();
    toggle_ready = 1'b0;
    @(negedge clk); ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (!trace_valid) break;
    end
    check("drain_done_valid", trace_valid, 0);
    check("drain_sb_empty", sb.size(), 0);
  endtask

  always @(negedge clk) if (toggle_ready) ready = ~ready;

  // Monitor: samples just after the negedge, i.e. the values the next posedge will see.
  initial begin
    logic        stall_prev;
    logic [19:0] data_prev, exp;
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid_held", trace_valid, 1);
          check("stall_data_stable", trace_data, data_prev);
        end
        if (trace_valid && ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_record: got %h expected none", trace_data);
          end else begin
            exp = sb.pop_front();
            check("record", trace_data, exp);
          end
        end
        stall_prev = trace_valid && !ready;
        data_prev  = trace_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; phi2 = 1'b0; sync = 1'b0; d = 4'h0; en = 1'b1; ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", trace_valid, 0);
    check("rst_data", trace_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_locked", locked, 0);
    check("rst_sync_err", sync_err_cnt, 0);
    check("rst_ovf", ovf_cnt, 0);
    rst = 1'b0;

    // Lock: SYNC seen while hunting stands in for X3.
    phase(1'b1, 4'h0); #1;
    check("lock_after_sync", locked, 1);

    // T2: single fetch, record presented one cycle after the X1 tick.
    ready = 1'b1;
    sb.push_back(20'h123D4);
    phase(1'b0, 4'h3); phase(1'b0, 4'h2); phase(1'b0, 4'h1);
    phase(1'b0, 4'hD); phase(1'b0, 4'h4); #1;
    check("t2_valid_before_x1", trace_valid, 0);
    phase(1'b0, 4'h0); #1;
    check("t2_valid_after_x1", trace_valid, 1);
    check("t2_level_after_x1", fifo_level, 1);
    check("t2_data", trace_data, 20'h123D4);
    phase(1'b0, 4'h0); phase(1'b1, 4'h0); #1;
    check("t2_level_drained", fifo_level, 0);
    check("t2_sb_empty", sb.size(), 0);

    // T6: ready toggles every cycle, one instruction with capture disabled.
    toggle_ready = 1'b1;
    instr(12'hA5C, 4'h2, 4'h7, 1'b1, 1'b1);
    instr(12'h3F0, 4'hE, 4'h1, 1'b0, 1'b0);
    #1; check("t6_locked_after_en0", locked, 1);
    instr(12'h001, 4'h9, 4'hB, 1'b1, 1'b1);
    instr(12'hFFE, 4'h4, 4'hC, 1'b1, 1'b1);
    drain();

    // T3: SYNC at M1 is a misalignment; the partial record is discarded.
    phase(1'b0, 4'h1); phase(1'b0, 4'h2); phase(1'b0, 4'h3);
    phase(1'b1, 4'h0); #1;
    check("t3_err1", sync_err_cnt, 1);
    check("t3_still_locked", locked, 1);
    check("t3_no_push", fifo_level, 0);
    instr(12'h456, 4'h7, 4'h8, 1'b1, 1'b1, 1'b0);
    #1;
    check("t3_unlocked", locked, 0);
    check("t3_err2", sync_err_cnt, 2);
    drain();

    // T4: overflow with the consumer stalled.
    phase(1'b1, 4'h0);
    ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      instr(12'h100 + 12'(i), 4'(i), 4'(15 - i), 1'b1, i < 16);
      if (i == 15) begin
        #1;
        check("t4_level_full", fifo_level, 16);
        check("t4_ovf_before", ovf_cnt, 0);
      end
    end
    #1;
    check("t4_level_after_ovf", fifo_level, 16);
    check("t4_ovf", ovf_cnt, 1);

    // T5: full FIFO, pop in the same cycle as the push.
    instr(12'h1FF, 4'h5, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check("t5_level", fifo_level, 16);
    check("t5_ovf", ovf_cnt, 1);
    drain();

    // T1: reset mid-stream with a record pending and a cycle half done.
    ready = 1'b0;
    instr(12'h777, 4'h1, 4'h2, 1'b1, 1'b0);
    phase(1'b0, 4'h9); phase(1'b0, 4'h8);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    sb.delete();
    check("t1_valid", trace_valid, 0);
    check("t1_data", trace_data, 0);
    check("t1_level", fifo_level, 0);
    check("t1_locked", locked, 0);
    check("t1_sync_err", sync_err_cnt, 0);
    check("t1_ovf", ovf_cnt, 0);
    rst = 1'b0;
    phase(1'b0, 4'h0); #1;
    check("t1_no_lock_without_sync", locked, 0);
    phase(1'b1, 4'h0); #1;
    check("t1_relock", locked, 1);
    ready = 1'b1;
    instr(12'h9AB, 4'hC, 4'hD, 1'b1, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
